// File: rtl/bsg_demux_segmented_buffered.sv
`default_nettype none
// ============================================================================
// Module   : bsg_demux_segmented_buffered
// Purpose  : Segmented 1-to-2 demultiplexer. Each segment of an input beat is
//            steered to one of two buffered output channels (valid/yumi).
// Options  : BSG_DEMUX_SEGMENTED_BUFFERED_COUNT_EN adds per-channel enqueue
//            counters (count0_o/count1_o).
// Revision : 1.0 - initial release
// ============================================================================
module bsg_demux_segmented_buffered #(
    parameter int segments_p      = 2,
    parameter int segment_width_p = 8,
    parameter int els_p           = 2
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic                                   v_i,
    input  logic [segments_p*segment_width_p-1:0]  data_i,
    input  logic [segments_p-1:0]                  sel_i,
    output logic                                   ready_o,
    output logic                                   v0_o,
    output logic [segments_p*segment_width_p-1:0]  data0_o,
    output logic [segments_p-1:0]                  mask0_o,
    input  logic                                   yumi0_i,
    output logic                                   v1_o,
    output logic [segments_p*segment_width_p-1:0]  data1_o,
    output logic [segments_p-1:0]                  mask1_o,
    input  logic                                   yumi1_i
`ifdef BSG_DEMUX_SEGMENTED_BUFFERED_COUNT_EN
    ,
    output logic [15:0]                            count0_o,
    output logic [15:0]                            count1_o
`endif
);

    localparam int DATA_W = segments_p * segment_width_p;
    localparam int ENT_W  = DATA_W + segments_p;
    localparam int PTR_W  = $clog2(els_p);
    localparam int CNT_W  = $clog2(els_p + 1);

    logic                  w_accept;
    logic [1:0]            w_full;
    logic [1:0]            w_valid;
    logic [1:0]            w_yumi;
    logic [DATA_W-1:0]     w_enq_data [2];
    logic [segments_p-1:0] w_enq_mask [2];
    logic [DATA_W-1:0]     w_head_data [2];
    logic [segments_p-1:0] w_head_mask [2];
`ifdef BSG_DEMUX_SEGMENTED_BUFFERED_COUNT_EN
    logic [15:0]           w_beats [2];
`endif

    // Ready deliberately ignores sel_i: either full channel stalls the input.
    assign ready_o  = ~reset_i & ~w_full[0] & ~w_full[1];
    assign w_accept = v_i & ready_o;
    assign w_yumi   = {yumi1_i, yumi0_i};

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            w_enq_data[k] = '0;
            w_enq_mask[k] = '0;
        end
        for (int s = 0; s < segments_p; s++) begin
            if (sel_i[s]) begin
                w_enq_data[1][s*segment_width_p +: segment_width_p] =
                    data_i[s*segment_width_p +: segment_width_p];
                w_enq_mask[1][s] = 1'b1;
            end else begin
                w_enq_data[0][s*segment_width_p +: segment_width_p] =
                    data_i[s*segment_width_p +: segment_width_p];
                w_enq_mask[0][s] = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < 2; k++) begin : g_ch
        logic [PTR_W-1:0] rptr_q, rptr_d;
        logic [PTR_W-1:0] wptr_q, wptr_d;
        logic [CNT_W-1:0] count_q, count_d;
        logic [ENT_W-1:0] mem_q [els_p];
        logic             w_enq;
        logic             w_deq;

        assign w_enq = w_accept & (|w_enq_mask[k]);
        // A yumi against an empty channel is dropped so the count cannot underflow.
        assign w_deq = w_yumi[k] & (count_q != '0);

        always_comb begin
            rptr_d  = rptr_q;
            wptr_d  = wptr_q;
            count_d = count_q;
            if (w_enq) wptr_d = wptr_q + PTR_W'(1);
            if (w_deq) rptr_d = rptr_q + PTR_W'(1);
            if (w_enq & ~w_deq)      count_d = count_q + CNT_W'(1);
            else if (~w_enq & w_deq) count_d = count_q - CNT_W'(1);
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                rptr_q  <= '0;
                wptr_q  <= '0;
                count_q <= '0;
            end else begin
                rptr_q  <= rptr_d;
                wptr_q  <= wptr_d;
                count_q <= count_d;
            end
        end

        always_ff @(posedge clk_i) begin
            if (w_enq) mem_q[wptr_q] <= {w_enq_data[k], w_enq_mask[k]};
        end

        assign w_full[k]  = (count_q == CNT_W'(els_p));
        assign w_valid[k] = (count_q != '0);
        assign {w_head_data[k], w_head_mask[k]} = mem_q[rptr_q];

`ifdef BSG_DEMUX_SEGMENTED_BUFFERED_COUNT_EN
        logic [15:0] beats_q, beats_d;

        always_comb begin
            beats_d = beats_q;
            if (w_enq) beats_d = beats_q + 16'd1;
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) beats_q <= '0;
            else         beats_q <= beats_d;
        end

        assign w_beats[k] = beats_q;
`endif
    end

    assign v0_o    = w_valid[0];
    assign data0_o = w_head_data[0];
    assign mask0_o = w_head_mask[0];
    assign v1_o    = w_valid[1];
    assign data1_o = w_head_data[1];
    assign mask1_o = w_head_mask[1];
`ifdef BSG_DEMUX_SEGMENTED_BUFFERED_COUNT_EN
    assign count0_o = w_beats[0];
    assign count1_o = w_beats[1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_bsg_demux_segmented_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_bsg_demux_segmented_buffered
// Purpose  : Self-checking bench: directed vector table, hand sequences and
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bsg_demux_segmented_buffered;

    localparam int S   = 2;
    localparam int SW  = 8;
    localparam int DW  = S * SW;
    localparam int ELS = 2;

    logic          clk = 1'b0;
    logic          reset_i = 1'b0;
    logic          v_i = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic [S-1:0]  sel_i = '0;
    logic          yumi0_i = 1'b0;
    logic          yumi1_i = 1'b0;
    logic          ready_o, v0_o, v1_o;
    logic [DW-1:0] data0_o, data1_o;
    logic [S-1:0]  mask0_o, mask1_o;
`ifdef BSG_DEMUX_SEGMENTED_BUFFERED_COUNT_EN
    logic [15:0]   count0_o, count1_o;
`endif

    bsg_demux_segmented_buffered #(
        .segments_p     (S),
        .segment_width_p(SW),
        .els_p          (ELS)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .v_i     (v_i),
        .data_i  (data_i),
        .sel_i   (sel_i),
        .ready_o (ready_o),
        .v0_o    (v0_o),
        .data0_o (data0_o),
        .mask0_o (mask0_o),
        .yumi0_i (yumi0_i),
        .v1_o    (v1_o),
        .data1_o (data1_o),
        .mask1_o (mask1_o),
        .yumi1_i (yumi1_i)
`ifdef BSG_DEMUX_SEGMENTED_BUFFERED_COUNT_EN
        ,
        .count0_o(count0_o),
        .count1_o(count1_o)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [S-1:0]  m;
    } ent_t;

    ent_t q0[$];
    ent_t q1[$];
    int   cnt0 = 0;
    int   cnt1 = 0;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic [S-1:0]  sel;
        logic          y0;
        logic          y1;
        logic          ev0;
        logic [DW-1:0] ed0;
        logic [S-1:0]  em0;
        logic          ev1;
        logic [DW-1:0] ed1;
        logic [S-1:0]  em1;
        logic          erdy;
    } vec_t;

    vec_t tbl[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, advance model across the edge, compare.
    task automatic cycle(input logic v, input logic [DW-1:0] d, input logic [S-1:0] sel,
                         input logic y0, input logic y1);
        bit   rdy;
        ent_t e0, e1;
        v_i = v; data_i = d; sel_i = sel; yumi0_i = y0; yumi1_i = y1;
        rdy = (q0.size() < ELS) && (q1.size() < ELS);
        #1;
        check("ready_pre", {31'd0, ready_o}, {31'd0, rdy});
        @(posedge clk);
        #1;
        if (y0 && q0.size() > 0) void'(q0.pop_front());
        if (y1 && q1.size() > 0) void'(q1.pop_front());
        if (v && rdy) begin
            e0 = '{d: '0, m: '0};
            e1 = '{d: '0, m: '0};
            for (int s = 0; s < S; s++) begin
                if (sel[s]) begin
                    e1.d = e1.d | (d & (16'hFF << (s * SW)));
                    e1.m = e1.m | S'(1 << s);
                end else begin
                    e0.d = e0.d | (d & (16'hFF << (s * SW)));
                    e0.m = e0.m | S'(1 << s);
                end
            end
            if (e0.m != 0) begin q0.push_back(e0); cnt0 = (cnt0 + 1) % 65536; end
            if (e1.m != 0) begin q1.push_back(e1); cnt1 = (cnt1 + 1) % 65536; end
        end
        check("v0", {31'd0, v0_o}, {31'd0, q0.size() != 0});
        check("v1", {31'd0, v1_o}, {31'd0, q1.size() != 0});
        if (q0.size() != 0) begin
            check("data0", {16'd0, data0_o}, {16'd0, q0[0].d});
            check("mask0", {30'd0, mask0_o}, {30'd0, q0[0].m});
        end
        if (q1.size() != 0) begin
            check("data1", {16'd0, data1_o}, {16'd0, q1[0].d});
            check("mask1", {30'd0, mask1_o}, {30'd0, q1[0].m});
        end
`ifdef BSG_DEMUX_SEGMENTED_BUFFERED_COUNT_EN
        check("count0", {16'd0, count0_o}, cnt0);
        check("count1", {16'd0, count1_o}, cnt1);
`endif
    endtask

    // Asserts reset mid-cycle and checks outputs drop with no clock edge.
    task automatic do_reset();
        v_i = 1'b0; yumi0_i = 1'b0; yumi1_i = 1'b0;
        reset_i = 1'b1;
        #1;
        check("rst_v0", {31'd0, v0_o}, 32'd0);
        check("rst_v1", {31'd0, v1_o}, 32'd0);
        check("rst_ready", {31'd0, ready_o}, 32'd0);
        q0.delete(); q1.delete();
        cnt0 = 0; cnt1 = 0;
        @(negedge clk);
        reset_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 16'hA55A, 2'b00, 1'b0, 1'b0, 1'b1, 16'hA55A, 2'b11, 1'b0, 16'h0000, 2'b00, 1'b1};
        tbl[1]  = '{1'b1, 16'h1234, 2'b10, 1'b1, 1'b0, 1'b1, 16'h0034, 2'b01, 1'b1, 16'h1200, 2'b10, 1'b1};
        tbl[2]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b1};
        tbl[3]  = '{1'b1, 16'h1111, 2'b00, 1'b0, 1'b0, 1'b1, 16'h1111, 2'b11, 1'b0, 16'h0000, 2'b00, 1'b1};
        tbl[4]  = '{1'b1, 16'h2222, 2'b00, 1'b0, 1'b0, 1'b1, 16'h1111, 2'b11, 1'b0, 16'h0000, 2'b00, 1'b0};
        tbl[5]  = '{1'b1, 16'h3333, 2'b00, 1'b0, 1'b0, 1'b1, 16'h1111, 2'b11, 1'b0, 16'h0000, 2'b00, 1'b0};
        tbl[6]  = '{1'b1, 16'h3333, 2'b00, 1'b1, 1'b0, 1'b1, 16'h2222, 2'b11, 1'b0, 16'h0000, 2'b00, 1'b1};
        tbl[7]  = '{1'b1, 16'h3333, 2'b00, 1'b0, 1'b0, 1'b1, 16'h2222, 2'b11, 1'b0, 16'h0000, 2'b00, 1'b0};
        tbl[8]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 1'b1, 16'h3333, 2'b11, 1'b0, 16'h0000, 2'b00, 1'b1};
        tbl[9]  = '{1'b0, 16'h0000, 2'b00, 1'b1, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b1};
        tbl[10] = '{1'b1, 16'h4444, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 16'h4444, 2'b11, 1'b1};
        tbl[11] = '{1'b1, 16'h5555, 2'b11, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 16'h4444, 2'b11, 1'b0};
        tbl[12] = '{1'b1, 16'h6666, 2'b00, 1'b0, 1'b0, 1'b0, 16'h0000, 2'b00, 1'b1, 16'h4444, 2'b11, 1'b0};
        tbl[13] = '{1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b1, 16'h5555, 2'b11, 1'b1};
        tbl[14] = '{1'b0, 16'h0000, 2'b00, 1'b0, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b1};
        tbl[15] = '{1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b1};
        tbl[16] = '{1'b1, 16'hABCD, 2'b01, 1'b1, 1'b1, 1'b1, 16'hAB00, 2'b10, 1'b1, 16'h00CD, 2'b01, 1'b1};
        tbl[17] = '{1'b0, 16'h0000, 2'b00, 1'b1, 1'b1, 1'b0, 16'h0000, 2'b00, 1'b0, 16'h0000, 2'b00, 1'b1};

        #2;
        do_reset();
        check("post_rst_ready", {31'd0, ready_o}, 32'd1);
        check("post_rst_v0", {31'd0, v0_o}, 32'd0);
        check("post_rst_v1", {31'd0, v1_o}, 32'd0);

        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].sel, tbl[i].y0, tbl[i].y1);
            check($sformatf("tbl%0d_v0", i), {31'd0, v0_o}, {31'd0, tbl[i].ev0});
            check($sformatf("tbl%0d_v1", i), {31'd0, v1_o}, {31'd0, tbl[i].ev1});
            check($sformatf("tbl%0d_ready", i), {31'd0, ready_o}, {31'd0, tbl[i].erdy});
            if (tbl[i].ev0) begin
                check($sformatf("tbl%0d_d0", i), {16'd0, data0_o}, {16'd0, tbl[i].ed0});
                check($sformatf("tbl%0d_m0", i), {30'd0, mask0_o}, {30'd0, tbl[i].em0});
            end
            if (tbl[i].ev1) begin
                check($sformatf("tbl%0d_d1", i), {16'd0, data1_o}, {16'd0, tbl[i].ed1});
                check($sformatf("tbl%0d_m1", i), {30'd0, mask1_o}, {30'd0, tbl[i].em1});
            end
        end

        // Streaming through channel 1 across several pointer wraps.
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 16'hC000 + 16'(i * 16'h0101), 2'b11, 1'b0, v1_o);
            check("wrap_ready", {31'd0, ready_o}, 32'd1);
        end
        for (int i = 0; i < 2; i++) cycle(1'b0, 16'h0000, 2'b00, 1'b0, 1'b1);

        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom), 16'($urandom), 2'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
        end

        // Fill both channels, then discard everything with a mid-cycle reset.
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 2'b01, 1'b0, 1'b0);
        check("fill_ready", {31'd0, ready_o}, 32'd0);
        do_reset();
        cycle(1'b1, 16'hBEEF, 2'b00, 1'b0, 1'b0);
        check("after_rst_head", {16'd0, data0_o}, 32'h0000BEEF);
        check("after_rst_v1", {31'd0, v1_o}, 32'd0);

`ifdef BSG_DEMUX_SEGMENTED_BUFFERED_COUNT_EN
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 2'b01, v0_o, v1_o);
        check("cnt_a0", {16'd0, count0_o}, 32'd3);
        check("cnt_a1", {16'd0, count1_o}, 32'd3);
        cycle(1'b1, 16'h7777, 2'b11, v0_o, v1_o);
        check("cnt_b0", {16'd0, count0_o}, 32'd3);
        check("cnt_b1", {16'd0, count1_o}, 32'd4);
`endif

        v_i = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
